f_accel: RTL and testbench



---
 rtl/f_accel.sv | 127 ++++++++++++
 tb/tb_f_accel.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/f_accel.sv
// f_accel: memory-mapped iterative factorial accelerator.
// Host writes N (a=00) and go (a=01, d[0]=1), polls STATUS (a=10) and reads
// RESULT (a=11). Read data is a combinational mux of the register map.
// Optional feature: define FACCEL_OVF_EN to flag N>12 as overflow (err=1,
// RESULT forced to 0 at completion). Without it err is always 0 and RESULT
// is the product truncated to 32 bits.
//
// state | meaning
// IDLE  | waiting for a go write; done/err/result hold the last run
// BUSY  | multiplying product by cnt once per clock until cnt<=1
module f_accel (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [3:0]  d,
  output logic [31:0] out
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nx;
  logic [3:0]  n_reg;
  logic        g_reg;
  logic        done;
  logic        err;
  logic        busy;
  logic [31:0] result;
  logic [31:0] product;
  logic [3:0]  cnt;

  logic        start;
  logic        step;
  logic        finish;
  logic        ovf;
  logic [31:0] prod_nx;

  assign prod_nx = product * {28'd0, cnt};

`ifdef FACCEL_OVF_EN
  assign ovf = (n_reg > 4'd12);
`else
  assign ovf = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (we && (a == 2'b01) && d[0]) begin
          start    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt > 4'd1) begin
          step = 1'b1;
        end else begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Host-visible N and G registers; N is frozen while a run is active and
  // a go=1 write during a run is dropped, but go=0 may always clear G.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_reg <= 4'd0;
      g_reg <= 1'b0;
    end else if (we) begin
      if ((a == 2'b00) && (state != BUSY))
        n_reg <= d;
      if ((a == 2'b01) && ((state != BUSY) || !d[0]))
        g_reg <= d[0];
    end
  end

  // Iterative multiply datapath and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product <= 32'd0;
      cnt     <= 4'd0;
      result  <= 32'd0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else if (start) begin
      product <= 32'd1;
      cnt     <= n_reg;
      done    <= 1'b0;
      err     <= ovf;
      busy    <= 1'b1;
    end else if (step) begin
      product <= prod_nx;
      cnt     <= cnt - 4'd1;
    end else if (finish) begin
      result <= err ? 32'd0 : product;
      done   <= 1'b1;
      busy   <= 1'b0;
    end
  end

  // Combinational read mux.
  always_comb begin
    out = 32'd0;
    case (a)
      2'b00:   out = {28'd0, n_reg};
      2'b01:   out = {31'd0, g_reg};
      2'b10:   out = {29'd0, busy, err, done};
      default: out = result;
    endcase
  end

endmodule

// File: tb/tb_f_accel.sv
// Directed testbench for f_accel: reset, basic N=5 run, small/large N,
// mid-run writes, reset abort and overflow behaviour (FACCEL_OVF_EN aware).
module tb_f_accel;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  a;
  logic [3:0]  d;
  logic [31:0] out;

  int vectors = 0;
  int errors  = 0;

  f_accel dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .a   (a),
    .d   (d),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write one register; returns 1 time unit after the committing edge.
  task automatic wr(input logic [1:0] addr, input logic [3:0] data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    d  = data;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Set the address and let the combinational read settle.
  task automatic rd(input logic [1:0] addr, output logic [31:0] val);
    a = addr;
    #1;
    val = out;
  endtask

  // Count edges until STATUS.done reads 1 (bounded at 40 edges; 0 = timeout).
  task automatic wait_done(output int edges);
    logic [31:0] v;
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      rd(2'b10, v);
      if (v[0]) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b0;
    we  = 1'b0;
    a   = 2'b00;
    d   = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(i[1:0], v);
      vectors++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL reset_read a=%0d got %0d expected 0", i, v);
      end
    end
  endtask

  task automatic test_basic;
    logic [31:0] v;
    int first_done;
    wr(2'b00, 4'd5);
    wr(2'b01, 4'd1);
    first_done = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      rd(2'b10, v);
      vectors++;
      if (i < 5) begin
        if (v !== 32'd4) begin
          errors++;
          $display("FAIL busy_status edge=%0d got %0d expected 4", i, v);
        end
      end else if (v !== 32'd1) begin
        errors++;
        $display("FAIL done_status edge=%0d got %0d expected 1", i, v);
      end
    end
    rd(2'b00, v);
    vectors++;
    if (v !== 32'd5) begin errors++; $display("FAIL n_readback got %0d expected 5", v); end
    rd(2'b01, v);
    vectors++;
    if (v !== 32'd1) begin errors++; $display("FAIL g_readback got %0d expected 1", v); end
    rd(2'b11, v);
    vectors++;
    if (v !== 32'd120) begin errors++; $display("FAIL result_n5 got %0d expected 120", v); end
  endtask

  task automatic test_mid_run_writes;
    logic [31:0] v;
    int e;
    wr(2'b00, 4'd10);
    wr(2'b01, 4'd1);        // start edge; G stays 1, restart allowed
    wr(2'b00, 4'd3);        // edge 1: ignored
    wr(2'b01, 4'd1);        // edge 2: ignored, no restart
    rd(2'b00, v);
    vectors++;
    if (v !== 32'd10) begin errors++; $display("FAIL n_frozen got %0d expected 10", v); end
    rd(2'b11, v);
    vectors++;
    if (v !== 32'd120) begin errors++; $display("FAIL result_hold got %0d expected 120", v); end
    rd(2'b10, v);
    vectors++;
    if (v !== 32'd4) begin errors++; $display("FAIL midrun_status got %0d expected 4", v); end
    wait_done(e);
    vectors++;
    if (e == 0 || e + 2 != 10) begin
      errors++;
      $display("FAIL n10_latency got %0d expected 10", (e == 0) ? 0 : e + 2);
    end
    rd(2'b11, v);
    vectors++;
    if (v !== 32'd3628800) begin errors++; $display("FAIL result_n10 got %0d expected 3628800", v); end
  endtask

  task automatic test_small_n;
    logic [31:0] v;
    int e;
    for (int n = 0; n < 2; n++) begin
      wr(2'b00, n[3:0]);
      wr(2'b01, 4'd1);
      wait_done(e);
      vectors++;
      if (e != 1) begin errors++; $display("FAIL small_latency n=%0d got %0d expected 1", n, e); end
      rd(2'b11, v);
      vectors++;
      if (v !== 32'd1) begin errors++; $display("FAIL small_result n=%0d got %0d expected 1", n, v); end
    end
  endtask

  task automatic test_n12;
    logic [31:0] v;
    int e;
    wr(2'b00, 4'd12);
    wr(2'b01, 4'd1);
    wait_done(e);
    vectors++;
    if (e != 12) begin errors++; $display("FAIL n12_latency got %0d expected 12", e); end
    rd(2'b11, v);
    vectors++;
    if (v !== 32'd479001600) begin errors++; $display("FAIL result_n12 got %0d expected 479001600", v); end
    rd(2'b10, v);
    vectors++;
    if (v !== 32'd1) begin errors++; $display("FAIL status_n12 got %0d expected 1", v); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] v;
    wr(2'b00, 4'd9);
    wr(2'b01, 4'd1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    rd(2'b10, v);
    vectors++;
    if (v !== 32'd0) begin errors++; $display("FAIL abort_status got %0d expected 0", v); end
    rd(2'b11, v);
    vectors++;
    if (v !== 32'd0) begin errors++; $display("FAIL abort_result got %0d expected 0", v); end
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rd(2'b10, v);
    vectors++;
    if (v !== 32'd0) begin errors++; $display("FAIL no_completion got %0d expected 0", v); end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    logic [31:0] exp_status;
    logic [31:0] exp_result;
    int e;
`ifdef FACCEL_OVF_EN
    exp_status = 32'd3;
    exp_result = 32'd0;
`else
    exp_status = 32'd1;
    exp_result = 32'd1932053504;
`endif
    wr(2'b00, 4'd13);
    wr(2'b01, 4'd1);
    wait_done(e);
    vectors++;
    if (e != 13) begin errors++; $display("FAIL n13_latency got %0d expected 13", e); end
    rd(2'b10, v);
    vectors++;
    if (v !== exp_status) begin errors++; $display("FAIL status_n13 got %0d expected %0d", v, exp_status); end
    rd(2'b11, v);
    vectors++;
    if (v !== exp_result) begin errors++; $display("FAIL result_n13 got %0d expected %0d", v, exp_result); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mid_run_writes;
    test_small_n;
    test_n12;
    test_overflow;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
